// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the functional-unit result buses, the reorder-buffer flush and the
// registered common-data-bus broadcast into one interface.
//
// Handshake: FU i raises valid_bus[i] and holds its data/addr/RB_index
// stable until it sees grant[i]. The transfer completes at the rising edge
// where valid_bus[i] & grant[i] are both 1. At that edge the FU may drop the
// request or present a new one. grant is forced to 0 while flush is high.
//
// Modports:
//   master : FU side / environment. It drives the requests and flush, and
//            receives the grant and the broadcast.
//   slave  : the arbiter.
//
// Signals:
//   flush         reorder-buffer flush
//   valid_bus     per-FU request             [FU_NUM]
//   data_bus      per-FU result              [FU_NUM*WORD_SIZE]
//   addr_bus      per-FU store address       [FU_NUM*WORD_SIZE]
//   RB_index_bus  per-FU destination ROB idx [FU_NUM*RB_INDEX]
//   grant         one-hot combinational grant
//   cdb_valid, cdb_data, cdb_addr, cdb_RB_index, cdb_fu : registered broadcast
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int FU_NUM    = 4,
    parameter int FU_INDEX  = 2,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 3
) ();
    logic                          flush;
    logic [FU_NUM-1:0]             valid_bus;
    logic [FU_NUM*WORD_SIZE-1:0]   data_bus;
    logic [FU_NUM*WORD_SIZE-1:0]   addr_bus;
    logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus;
    logic [FU_NUM-1:0]             grant;
    logic                          cdb_valid;
    logic [WORD_SIZE-1:0]          cdb_data;
    logic [WORD_SIZE-1:0]          cdb_addr;
    logic [RB_INDEX-1:0]           cdb_RB_index;
    logic [FU_INDEX-1:0]           cdb_fu;

    modport master (
        output flush, valid_bus, data_bus, addr_bus, RB_index_bus,
        input  grant, cdb_valid, cdb_data, cdb_addr, cdb_RB_index, cdb_fu
    );

    modport slave (
        input  flush, valid_bus, data_bus, addr_bus, RB_index_bus,
        output grant, cdb_valid, cdb_data, cdb_addr, cdb_RB_index, cdb_fu
    );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for the single-lane common data bus. Each cycle the
// first requesting FU, scanning upward from the round-robin pointer, is
// granted combinationally. Its result, address, ROB index and FU number are
// registered onto the CDB and appear one cycle later. flush suppresses the
// grant and the broadcast. reset has priority over flush.
//
// Ports:
//   clk    in   system clock (rising edge)
//   reset  in   synchronous, active-high reset
//   bus    slave modport of cdb_arbiter_if (requests, flush, grant, CDB)
//
// Optional feature (macro CDB_ARB_PERF_EN):
//   grant_cnt     out 32  total transfers, saturating
//   conflict_cnt  out 32  transfer edges with two or more requesters,
//                         saturating
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int FU_NUM    = 4,
    parameter int FU_INDEX  = 2,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 3
) (
    input  logic                clk,
    input  logic                reset,
    cdb_arbiter_if.slave        bus
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]         grant_cnt,
    output logic [31:0]         conflict_cnt
`endif
);

    logic [FU_INDEX-1:0]  ptr_q, ptr_d;
    logic [FU_INDEX-1:0]  win;
    logic                 found;
    logic                 xfer;
    logic [FU_NUM-1:0]    grant_d;

    logic                 cdb_valid_q,    cdb_valid_d;
    logic [WORD_SIZE-1:0] cdb_data_q,     cdb_data_d;
    logic [WORD_SIZE-1:0] cdb_addr_q,     cdb_addr_d;
    logic [RB_INDEX-1:0]  cdb_rb_index_q, cdb_rb_index_d;
    logic [FU_INDEX-1:0]  cdb_fu_q,       cdb_fu_d;

    // Rotating priority scan. The first requester at or after ptr_q wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            if (!found && bus.valid_bus[(int'(ptr_q) + k) % FU_NUM]) begin
                found = 1'b1;
                win   = FU_INDEX'((int'(ptr_q) + k) % FU_NUM);
            end
        end
    end

    // A transfer needs a requester and no flush. reset is handled in the
    // register block, where it overrides everything.
    assign xfer = found & ~bus.flush;

    always_comb begin
        grant_d = '0;
        if (xfer) begin
            grant_d[win] = 1'b1;
        end
    end

    assign bus.grant = grant_d;

    always_comb begin
        ptr_d          = ptr_q;
        cdb_valid_d    = xfer;
        cdb_data_d     = cdb_data_q;
        cdb_addr_d     = cdb_addr_q;
        cdb_rb_index_d = cdb_rb_index_q;
        cdb_fu_d       = cdb_fu_q;
        if (xfer) begin
            // The winner gets lowest priority on the next scan.
            ptr_d          = FU_INDEX'((int'(win) + 1) % FU_NUM);
            cdb_data_d     = bus.data_bus[int'(win)*WORD_SIZE +: WORD_SIZE];
            cdb_addr_d     = bus.addr_bus[int'(win)*WORD_SIZE +: WORD_SIZE];
            cdb_rb_index_d = bus.RB_index_bus[int'(win)*RB_INDEX +: RB_INDEX];
            cdb_fu_d       = win;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q          <= '0;
            cdb_valid_q    <= 1'b0;
            cdb_data_q     <= '0;
            cdb_addr_q     <= '0;
            cdb_rb_index_q <= '0;
            cdb_fu_q       <= '0;
        end else begin
            ptr_q          <= ptr_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_data_q     <= cdb_data_d;
            cdb_addr_q     <= cdb_addr_d;
            cdb_rb_index_q <= cdb_rb_index_d;
            cdb_fu_q       <= cdb_fu_d;
        end
    end

    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_data     = cdb_data_q;
    assign bus.cdb_addr     = cdb_addr_q;
    assign bus.cdb_RB_index = cdb_rb_index_q;
    assign bus.cdb_fu       = cdb_fu_q;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] grant_cnt_q,    grant_cnt_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;
    logic        conflict;

    // A conflict is a transfer edge where somebody else also wanted the bus.
    assign conflict = xfer && ($countones(bus.valid_bus) >= 2);

    always_comb begin
        grant_cnt_d    = grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (xfer && grant_cnt_q != 32'hFFFF_FFFF) begin
            grant_cnt_d = grant_cnt_q + 32'd1;
        end
        if (conflict && conflict_cnt_q != 32'hFFFF_FFFF) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    localparam int FU_NUM    = 4;
    localparam int FU_INDEX  = 2;
    localparam int WORD_SIZE = 32;
    localparam int RB_INDEX  = 3;
    localparam int CW        = 1 + FU_INDEX + RB_INDEX + 2*WORD_SIZE;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.FU_NUM(FU_NUM), .FU_INDEX(FU_INDEX),
                     .WORD_SIZE(WORD_SIZE), .RB_INDEX(RB_INDEX)) bus ();

`ifdef CDB_ARB_PERF_EN
    logic [31:0] grant_cnt, conflict_cnt;
`endif

    cdb_arbiter #(.FU_NUM(FU_NUM), .FU_INDEX(FU_INDEX),
                  .WORD_SIZE(WORD_SIZE), .RB_INDEX(RB_INDEX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CDB_ARB_PERF_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    // Per-FU payload presented with each request.
    logic [WORD_SIZE-1:0] fu_data [FU_NUM];
    logic [WORD_SIZE-1:0] fu_addr [FU_NUM];
    logic [RB_INDEX-1:0]  fu_rb   [FU_NUM];

    // Reference model: rotating pointer, last broadcast, counters.
    int                   m_ptr   = 0;
    logic                 m_valid = 1'b0;
    logic [FU_INDEX-1:0]  m_fu    = '0;
    logic [RB_INDEX-1:0]  m_rb    = '0;
    logic [WORD_SIZE-1:0] m_addr  = '0;
    logic [WORD_SIZE-1:0] m_data  = '0;
    logic [31:0]          m_gcnt  = '0;
    logic [31:0]          m_ccnt  = '0;

    // Values captured by the driver for the tests to compare.
    logic [FU_NUM-1:0] obs_grant, exp_grant;
    logic [CW-1:0]     obs_cdb,   exp_cdb;

    // Fairness bookkeeping for the random test.
    int wait_cnt [FU_NUM];

    // Whichever requester comes first going round from p wins; -1 if none.
    function automatic int ref_winner(input logic [FU_NUM-1:0] v, input int p);
        for (int k = 0; k < FU_NUM; k++) begin
            if (v[(p + k) % FU_NUM]) return (p + k) % FU_NUM;
        end
        return -1;
    endfunction

    // ---------------- driver ----------------
    // Entered 1 time unit after a rising edge. The task applies the inputs,
    // samples outputs mid-cycle, crosses the next edge and advances the
    // model.
    task automatic drive_cycle(input logic [FU_NUM-1:0] v, input logic fl, input logic rs);
        int w;
        reset         = rs;
        bus.flush     = fl;
        bus.valid_bus = v;
        for (int i = 0; i < FU_NUM; i++) begin
            bus.data_bus[i*WORD_SIZE +: WORD_SIZE]   = fu_data[i];
            bus.addr_bus[i*WORD_SIZE +: WORD_SIZE]   = fu_addr[i];
            bus.RB_index_bus[i*RB_INDEX +: RB_INDEX] = fu_rb[i];
        end
        w = ref_winner(v, m_ptr);
        exp_grant = (w >= 0 && !fl) ? FU_NUM'(1 << w) : '0;
        exp_cdb   = {m_valid, m_fu, m_rb, m_addr, m_data};
        #3;
        obs_grant = bus.grant;
        obs_cdb   = {bus.cdb_valid, bus.cdb_fu, bus.cdb_RB_index, bus.cdb_addr, bus.cdb_data};
        @(posedge clk);
        if (rs) begin
            m_ptr = 0; m_valid = 0; m_fu = '0; m_rb = '0; m_addr = '0; m_data = '0;
            m_gcnt = '0; m_ccnt = '0;
        end else if (fl || w < 0) begin
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
            m_fu    = FU_INDEX'(w);
            m_rb    = fu_rb[w];
            m_addr  = fu_addr[w];
            m_data  = fu_data[w];
            m_ptr   = (w + 1) % FU_NUM;
            m_gcnt  = m_gcnt + 1;
            if ($countones(v) >= 2) m_ccnt = m_ccnt + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        drive_cycle('0, 1'b0, 1'b1);
    endtask

    task automatic load_payload(input logic [WORD_SIZE-1:0] base);
        for (int i = 0; i < FU_NUM; i++) begin
            fu_data[i] = base + WORD_SIZE'(i) + WORD_SIZE'($urandom_range(0, 255) << 8);
            fu_addr[i] = $urandom;
            fu_rb[i]   = RB_INDEX'($urandom_range(0, 7));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        load_payload(32'h1000_0000);
        drive_cycle(4'b1111, 1'b0, 1'b1);
        drive_cycle(4'b1111, 1'b0, 1'b1);
        checks++;
        if (obs_cdb !== '0) begin
            errors++;
            $display("FAIL reset_cdb: got %h expected 0", obs_cdb);
        end
        checks++;
        if (obs_grant !== 4'b0001) begin
            errors++;
            $display("FAIL reset_grant: got %b expected 0001", obs_grant);
        end
    endtask

    task automatic test_rotation();
        logic [FU_NUM-1:0] tbl [5];
        tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        load_payload(32'h2000_0000);
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive_cycle(c < 5 ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
            checks++;
            if (obs_grant !== (c < 5 ? tbl[c] : exp_grant) || obs_grant !== exp_grant) begin
                errors++;
                $display("FAIL rotation_grant[%0d]: got %b expected %b", c, obs_grant, exp_grant);
            end
            checks++;
            if (obs_cdb !== exp_cdb) begin
                errors++;
                $display("FAIL rotation_cdb[%0d]: got %h expected %h", c, obs_cdb, exp_cdb);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (bus.cdb_fu !== FU_INDEX'(c) || bus.cdb_data !== fu_data[c] || bus.cdb_RB_index !== fu_rb[c]) begin
                    errors++;
                    $display("FAIL rotation_fu[%0d]: got fu %0d data %h expected fu %0d data %h",
                             c, bus.cdb_fu, bus.cdb_data, c, fu_data[c]);
                end
            end
        end
    endtask

    task automatic test_single();
        load_payload(32'h3000_0000);
        fu_data[2] = 32'h0000_00AA;
        fu_rb[2]   = 3'd5;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive_cycle(c < 3 ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
            checks++;
            if (obs_grant !== (c < 3 ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL single_grant[%0d]: got %b expected %b", c, obs_grant, exp_grant);
            end
            checks++;
            if (obs_cdb !== exp_cdb) begin
                errors++;
                $display("FAIL single_cdb[%0d]: got %h expected %h", c, obs_cdb, exp_cdb);
            end
        end
        // Cycle after the third grant still shows FU2's broadcast.
        checks++;
        if ({bus.cdb_valid, bus.cdb_data, bus.cdb_RB_index} !== {1'b0, 32'h0000_00AA, 3'd5}) begin
            errors++;
            $display("FAIL single_tail: got v%b %h rb%0d expected v0 000000aa rb5",
                     bus.cdb_valid, bus.cdb_data, bus.cdb_RB_index);
        end
    endtask

    task automatic test_pattern_1010();
        logic [FU_NUM-1:0] vin [5];
        logic [FU_NUM-1:0] gex [5];
        vin = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b0000};
        gex = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000};
        load_payload(32'h4000_0000);
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive_cycle(vin[c], 1'b0, 1'b0);
            checks++;
            if (obs_grant !== gex[c] || obs_grant !== exp_grant) begin
                errors++;
                $display("FAIL p1010_grant[%0d]: got %b expected %b", c, obs_grant, gex[c]);
            end
            checks++;
            if (obs_cdb !== exp_cdb) begin
                errors++;
                $display("FAIL p1010_cdb[%0d]: got %h expected %h", c, obs_cdb, exp_cdb);
            end
        end
        checks++;
        if (bus.cdb_fu !== 2'd3) begin
            errors++;
            $display("FAIL p1010_last_fu: got %0d expected 3", bus.cdb_fu);
        end
    endtask

    task automatic test_flush();
        load_payload(32'h5000_0000);
        do_reset();
        drive_cycle(4'b0011, 1'b1, 1'b0);
        checks++;
        if (obs_grant !== 4'b0000) begin
            errors++;
            $display("FAIL flush_grant: got %b expected 0000", obs_grant);
        end
        drive_cycle(4'b0011, 1'b0, 1'b0);
        checks++;
        if (obs_cdb[CW-1] !== 1'b0 || obs_cdb !== exp_cdb) begin
            errors++;
            $display("FAIL flush_cdb: got %h expected %h", obs_cdb, exp_cdb);
        end
        checks++;
        if (obs_grant !== 4'b0001) begin
            errors++;
            $display("FAIL flush_release_grant: got %b expected 0001", obs_grant);
        end
        drive_cycle(4'b0000, 1'b0, 1'b0);
        checks++;
        if (obs_cdb !== exp_cdb || bus.cdb_fu !== 2'd0) begin
            errors++;
            $display("FAIL flush_release_cdb: got %h expected %h", obs_cdb, exp_cdb);
        end
    endtask

    task automatic test_midstream_reset();
        load_payload(32'h6000_0000);
        do_reset();
        drive_cycle(4'b0010, 1'b0, 1'b0);
        drive_cycle(4'b0011, 1'b0, 1'b1);
        checks++;
        if (obs_cdb !== exp_cdb || bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre: got %h expected %h", obs_cdb, exp_cdb);
        end
        drive_cycle(4'b0011, 1'b0, 1'b0);
        checks++;
        if (obs_cdb !== '0) begin
            errors++;
            $display("FAIL midreset_cdb: got %h expected 0", obs_cdb);
        end
        checks++;
        if (obs_grant !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_grant: got %b expected 0001", obs_grant);
        end
    endtask

    task automatic test_random();
        logic [FU_NUM-1:0] v;
        logic fl, rs;
        load_payload(32'h7000_0000);
        do_reset();
        v = '0;
        for (int i = 0; i < FU_NUM; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 600; c++) begin
            fl = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 149) == 0);
            drive_cycle(v, fl, rs);
            checks++;
            if (obs_grant !== exp_grant) begin
                errors++;
                $display("FAIL random_grant[%0d]: got %b expected %b", c, obs_grant, exp_grant);
            end
            checks++;
            if (obs_cdb !== exp_cdb) begin
                errors++;
                $display("FAIL random_cdb[%0d]: got %h expected %h", c, obs_cdb, exp_cdb);
            end
            // A held request must win within FU_NUM unflushed cycles.
            for (int i = 0; i < FU_NUM; i++) begin
                if (rs) wait_cnt[i] = 0;
                else if (v[i] && !exp_grant[i] && !fl) wait_cnt[i]++;
                else if (exp_grant[i]) wait_cnt[i] = 0;
            end
            for (int i = 0; i < FU_NUM; i++) begin
                if (v[i] && wait_cnt[i] >= FU_NUM) begin
                    checks++;
                    errors++;
                    $display("FAIL random_fairness[%0d]: fu %0d waited %0d cycles, limit %0d",
                             c, i, wait_cnt[i], FU_NUM - 1);
                    wait_cnt[i] = 0;
                end
            end
            // Requests are held until granted; after a grant or when idle a
            // new request with fresh payload may appear.
            for (int i = 0; i < FU_NUM; i++) begin
                if (!v[i] || exp_grant[i]) begin
                    v[i]       = ($urandom_range(0, 2) != 0);
                    fu_data[i] = $urandom;
                    fu_addr[i] = $urandom;
                    fu_rb[i]   = RB_INDEX'($urandom_range(0, 7));
                end
            end
        end
    endtask

`ifdef CDB_ARB_PERF_EN
    task automatic test_perf();
        load_payload(32'h8000_0000);
        do_reset();
        for (int c = 0; c < 10; c++) drive_cycle(4'b0110, 1'b0, 1'b0);
        checks++;
        if (grant_cnt !== 32'd10 || conflict_cnt !== 32'd10 || grant_cnt !== m_gcnt) begin
            errors++;
            $display("FAIL perf_0110: got g%0d c%0d expected g10 c10", grant_cnt, conflict_cnt);
        end
        for (int c = 0; c < 5; c++) drive_cycle(4'b0001, 1'b0, 1'b0);
        checks++;
        if (grant_cnt !== 32'd15 || conflict_cnt !== 32'd10 || conflict_cnt !== m_ccnt) begin
            errors++;
            $display("FAIL perf_0001: got g%0d c%0d expected g15 c10", grant_cnt, conflict_cnt);
        end
        drive_cycle(4'b1111, 1'b1, 1'b0);
        checks++;
        if (grant_cnt !== 32'd15 || conflict_cnt !== 32'd10) begin
            errors++;
            $display("FAIL perf_flush: got g%0d c%0d expected g15 c10", grant_cnt, conflict_cnt);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        bus.flush        = 1'b0;
        bus.valid_bus    = '0;
        bus.data_bus     = '0;
        bus.addr_bus     = '0;
        bus.RB_index_bus = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            fu_data[i] = '0; fu_addr[i] = '0; fu_rb[i] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_rotation();
        test_single();
        test_pattern_1010();
        test_flush();
        test_midstream_reset();
        test_random();
`ifdef CDB_ARB_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
